biquad8_coeff_loader: RTL and testbench

//  Upstream coefficient sequencer for the 8-sample incremental biquad stage.

---
 rtl/biquad8_coeff_loader.sv | 193 +++++++++++++++++++
 tb/tb_biquad8_coeff_loader.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/biquad8_coeff_loader.sv
// biquad8_coeff_loader
//   Coefficient sequencer for the 8-sample incremental biquad stage. The host
//   fills a staging bank while the block is idle. A commit replays the bank
//   highest address first onto the shared 18-bit B-cascade write bus. After a
//   programmable quiet gap it issues one update strobe, so every DSP pair
//   switches to the new coefficients on the same cycle.
//
//   Parameters
//     NCOEFF      staging entries (= B cascade depth)
//     ADRBITS     staging address width, 2**ADRBITS >= NCOEFF
//     UPDATE_GAP  idle cycles between the last coeff_wr_o and coeff_update_o
//
//   Ports
//     clk, rst        clock, synchronous active-high reset
//     wr_i/adr_i/dat_i  staging write (accepted only while idle)
//     commit_i        start a load sequence
//     busy_o          sequence in progress
//     done_o          1-cycle pulse at the end of a sequence
//     overrun_o       sticky: a write or commit arrived while busy
//     coeff_dat_o     registered coefficient word to the biquad
//     coeff_wr_o      B1 cascade shift strobe
//     coeff_update_o  B2 load strobe
//     rd_adr_i/rd_dat_o  staging readback, present only when
//                        BIQUAD8_COEFF_READBACK_EN is defined
//
//   Build option
//     BIQUAD8_COEFF_READBACK_EN  adds the registered staging readback port

module biquad8_coeff_loader #(
    parameter int unsigned NCOEFF     = 2,
    parameter int unsigned ADRBITS    = 1,
    parameter int unsigned UPDATE_GAP = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               wr_i,
    input  logic [ADRBITS-1:0] adr_i,
    input  logic [17:0]        dat_i,
    input  logic               commit_i,
`ifdef BIQUAD8_COEFF_READBACK_EN
    input  logic [ADRBITS-1:0] rd_adr_i,
    output logic [17:0]        rd_dat_o,
`endif
    output logic               busy_o,
    output logic               done_o,
    output logic               overrun_o,
    output logic [17:0]        coeff_dat_o,
    output logic               coeff_wr_o,
    output logic               coeff_update_o
);

    localparam int unsigned        GW       = (UPDATE_GAP > 1) ? $clog2(UPDATE_GAP) : 1;
    localparam logic [ADRBITS:0]   NCOEFF_W = (ADRBITS+1)'(NCOEFF);
    localparam logic [ADRBITS-1:0] K_TOP    = ADRBITS'(NCOEFF - 1);
    localparam logic [GW-1:0]      GAP_TOP  = (UPDATE_GAP > 0) ? GW'(UPDATE_GAP - 1) : '0;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SHIFT,
        S_GAP,
        S_UPDATE,
        S_DONE
    } state_t;

    state_t             state_q, state_n;
    logic [ADRBITS-1:0] k_q, k_n;
    logic [GW-1:0]      gap_q, gap_n;
    logic [17:0]        stage_q [NCOEFF];

    logic               idle;
    logic               stage_we;
    logic               commit_ok;
    logic               reject;
    logic               overrun_n;
    logic [17:0]        shift_word;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            k_q     <= '0;
            gap_q   <= '0;
        end else begin
            state_q <= state_n;
            k_q     <= k_n;
            gap_q   <= gap_n;
        end
    end

    // ------------------------------------------------------------------
    // Next-state, staging control and shift-word selection
    // ------------------------------------------------------------------
    always_comb begin
        state_n    = state_q;
        k_n        = k_q;
        gap_n      = gap_q;
        shift_word = '0;

        idle      = (state_q == S_IDLE);
        stage_we  = idle && wr_i && ({1'b0, adr_i} < NCOEFF_W);
        commit_ok = idle && commit_i;
        reject    = !idle && (wr_i || commit_i);
        overrun_n = commit_ok ? 1'b0 : (overrun_o || reject);

        case (state_q)
            S_IDLE: begin
                if (commit_i) begin
                    state_n = S_SHIFT;
                    k_n     = K_TOP;
                end
            end
            S_SHIFT: begin
                if (k_q == '0) begin
                    gap_n   = GAP_TOP;
                    state_n = (UPDATE_GAP == 0) ? S_UPDATE : S_GAP;
                end else begin
                    k_n = k_q - ADRBITS'(1);
                end
            end
            S_GAP: begin
                if (gap_q == '0) begin
                    state_n = S_UPDATE;
                end else begin
                    gap_n = gap_q - GW'(1);
                end
            end
            S_UPDATE: state_n = S_DONE;
            S_DONE:   state_n = S_IDLE;
            default:  state_n = S_IDLE;
        endcase

        // Word for the next shift cycle. A staging write in the commit cycle
        // is forwarded so it becomes part of this very sequence.
        for (int unsigned i = 0; i < NCOEFF; i++) begin
            if (k_n == ADRBITS'(i)) begin
                shift_word = (stage_we && (adr_i == ADRBITS'(i))) ? dat_i : stage_q[i];
            end
        end
    end

    // ------------------------------------------------------------------
    // Registered outputs (decoded from the next state so they line up with
    // the state they describe) and the staging bank
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_o         <= 1'b0;
            done_o         <= 1'b0;
            overrun_o      <= 1'b0;
            coeff_dat_o    <= '0;
            coeff_wr_o     <= 1'b0;
            coeff_update_o <= 1'b0;
            for (int unsigned i = 0; i < NCOEFF; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            busy_o         <= (state_n != S_IDLE);
            done_o         <= (state_n == S_DONE);
            overrun_o      <= overrun_n;
            coeff_wr_o     <= (state_n == S_SHIFT);
            coeff_update_o <= (state_n == S_UPDATE);
            if (state_n == S_SHIFT) begin
                coeff_dat_o <= shift_word;
            end
            for (int unsigned i = 0; i < NCOEFF; i++) begin
                if (stage_we && (adr_i == ADRBITS'(i))) begin
                    stage_q[i] <= dat_i;
                end
            end
        end
    end

`ifdef BIQUAD8_COEFF_READBACK_EN
    // Registered readback; unmapped addresses return zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_dat_o <= '0;
        end else begin
            rd_dat_o <= '0;
            for (int unsigned i = 0; i < NCOEFF; i++) begin
                if (rd_adr_i == ADRBITS'(i)) begin
                    rd_dat_o <= stage_q[i];
                end
            end
        end
    end
`else
    // Staging bank is write-only in this build.
`endif

endmodule

// File: tb/tb_biquad8_coeff_loader.sv
`timescale 1ns/1ps
module tb_biquad8_coeff_loader;

    localparam int N0 = 2;
    localparam int G0 = 2;
    localparam int N1 = 4;
    localparam int G1 = 0;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    logic        wr0, commit0;
    logic [0:0]  adr0;
    logic [17:0] dat0;
    logic        busy0, done0, ovr0, cwr0, cupd0;
    logic [17:0] cdat0;

    logic        wr1, commit1;
    logic [2:0]  adr1;
    logic [17:0] dat1;
    logic        busy1, done1, ovr1, cwr1, cupd1;
    logic [17:0] cdat1;

`ifdef BIQUAD8_COEFF_READBACK_EN
    logic [0:0]  rd_adr0;
    logic [17:0] rd_dat0;
    logic [2:0]  rd_adr1;
    logic [17:0] rd_dat1;
`endif

    int vectors     = 0;
    int miscompares = 0;

    // Reference staging contents
    logic [17:0] m0 [N0];
    logic [17:0] m1 [N1];

    biquad8_coeff_loader #(.NCOEFF(N0), .ADRBITS(1), .UPDATE_GAP(G0)) u0 (
        .clk(clk), .rst(rst), .wr_i(wr0), .adr_i(adr0), .dat_i(dat0), .commit_i(commit0),
`ifdef BIQUAD8_COEFF_READBACK_EN
        .rd_adr_i(rd_adr0), .rd_dat_o(rd_dat0),
`endif
        .busy_o(busy0), .done_o(done0), .overrun_o(ovr0),
        .coeff_dat_o(cdat0), .coeff_wr_o(cwr0), .coeff_update_o(cupd0)
    );

    biquad8_coeff_loader #(.NCOEFF(N1), .ADRBITS(3), .UPDATE_GAP(G1)) u1 (
        .clk(clk), .rst(rst), .wr_i(wr1), .adr_i(adr1), .dat_i(dat1), .commit_i(commit1),
`ifdef BIQUAD8_COEFF_READBACK_EN
        .rd_adr_i(rd_adr1), .rd_dat_o(rd_dat1),
`endif
        .busy_o(busy1), .done_o(done1), .overrun_o(ovr1),
        .coeff_dat_o(cdat1), .coeff_wr_o(cwr1), .coeff_update_o(cupd1)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write0(input logic [0:0] a, input logic [17:0] d);
        wr0 = 1'b1; adr0 = a; dat0 = d;
        tick();
        wr0 = 1'b0;
        m0[a] = d;
    endtask

    task automatic write1(input logic [2:0] a, input logic [17:0] d);
        wr1 = 1'b1; adr1 = a; dat1 = d;
        tick();
        wr1 = 1'b0;
        if (a < 3'd4) m1[a[1:0]] = d;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        wr0 = 0; commit0 = 0; adr0 = '0; dat0 = '0;
        wr1 = 0; commit1 = 0; adr1 = '0; dat1 = '0;
`ifdef BIQUAD8_COEFF_READBACK_EN
        rd_adr0 = '0; rd_adr1 = '0;
`endif
        for (int i = 0; i < N0; i++) m0[i] = '0;
        for (int i = 0; i < N1; i++) m1[i] = '0;
        repeat (3) tick();
        vectors++;
        if ({busy0, done0, ovr0, cwr0, cupd0, cdat0} !== 23'd0) begin
            miscompares++;
            $display("FAIL reset_u0 outputs got %h exp 0", {busy0, done0, ovr0, cwr0, cupd0, cdat0});
        end
        vectors++;
        if ({busy1, done1, ovr1, cwr1, cupd1, cdat1} !== 23'd0) begin
            miscompares++;
            $display("FAIL reset_u1 outputs got %h exp 0", {busy1, done1, ovr1, cwr1, cupd1, cdat1});
        end
        rst = 1'b0;
        tick();
    endtask

    // Directed load: stage[0]=0x00123, stage[1]=0x3FF00
    task automatic test_basic();
        logic [17:0] snap [N0];
        logic [4:0]  ef, gf;
        logic [17:0] ed;
        write0(1'b0, 18'h00123);
        write0(1'b1, 18'h3FF00);
        commit0 = 1'b1; tick(); commit0 = 1'b0;
        snap = m0;
        for (int c = 1; c <= 8; c++) begin
            ed = (c <= N0) ? snap[N0 - c] : snap[0];
            ef = {c <= N0 + G0 + 2, c == N0 + G0 + 2, 1'b0, c <= N0, c == N0 + G0 + 1};
            gf = {busy0, done0, ovr0, cwr0, cupd0};
            vectors++;
            if (gf !== ef || cdat0 !== ed) begin
                miscompares++;
                $display("FAIL basic c=%0d busy/done/ovr/wr/upd got %b exp %b dat got %h exp %h", c, gf, ef, cdat0, ed);
            end
            tick();
        end
    endtask

    // Write in the commit cycle is part of the sequence (both addresses)
    task automatic test_same_cycle_write();
        logic [17:0] snap [N0];
        logic [4:0]  ef, gf;
        logic [17:0] ed;
        for (int a = 0; a < N0; a++) begin
            wr0 = 1'b1; adr0 = 1'(a);
            dat0 = (a == 0) ? 18'h00055 : 18'($urandom);
            commit0 = 1'b1;
            m0[a] = dat0;
            tick();
            wr0 = 1'b0; commit0 = 1'b0;
            snap = m0;
            for (int c = 1; c <= 7; c++) begin
                ed = (c <= N0) ? snap[N0 - c] : snap[0];
                ef = {c <= N0 + G0 + 2, c == N0 + G0 + 2, 1'b0, c <= N0, c == N0 + G0 + 1};
                gf = {busy0, done0, ovr0, cwr0, cupd0};
                vectors++;
                if (gf !== ef || cdat0 !== ed) begin
                    miscompares++;
                    $display("FAIL same_cycle a=%0d c=%0d flags got %b exp %b dat got %h exp %h", a, c, gf, ef, cdat0, ed);
                end
                tick();
            end
        end
    endtask

    // Write+commit while busy are dropped and set overrun; next commit clears it
    task automatic test_overrun();
        logic [17:0] snap [N0];
        logic [4:0]  ef, gf;
        logic [17:0] ed;
        commit0 = 1'b1; tick(); commit0 = 1'b0;
        snap = m0;
        for (int c = 1; c <= 8; c++) begin
            if (c == 2) begin
                wr0 = 1'b1; adr0 = 1'b0; dat0 = ~snap[0]; commit0 = 1'b1;
            end else begin
                wr0 = 1'b0; commit0 = 1'b0;
            end
            ed = (c <= N0) ? snap[N0 - c] : snap[0];
            ef = {c <= N0 + G0 + 2, c == N0 + G0 + 2, c >= 3, c <= N0, c == N0 + G0 + 1};
            gf = {busy0, done0, ovr0, cwr0, cupd0};
            vectors++;
            if (gf !== ef || cdat0 !== ed) begin
                miscompares++;
                $display("FAIL overrun c=%0d flags got %b exp %b dat got %h exp %h", c, gf, ef, cdat0, ed);
            end
            tick();
        end
        commit0 = 1'b1; tick(); commit0 = 1'b0;
        vectors++;
        if ({ovr0, cwr0, cdat0} !== {1'b0, 1'b1, snap[N0 - 1]}) begin
            miscompares++;
            $display("FAIL overrun_clear ovr/wr/dat got %b/%b/%h exp 0/1/%h", ovr0, cwr0, cdat0, snap[N0 - 1]);
        end
        repeat (7) tick();
    endtask

    // Reset mid-sequence: outputs 0 next cycle, no update, staging cleared
    task automatic test_reset_mid();
        int upd_seen;
        write0(1'b1, 18'($urandom) | 18'h1);
        commit0 = 1'b1; tick(); commit0 = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < N0; i++) m0[i] = '0;
        for (int i = 0; i < N1; i++) m1[i] = '0;
        vectors++;
        if ({busy0, done0, ovr0, cwr0, cupd0, cdat0} !== 23'd0) begin
            miscompares++;
            $display("FAIL reset_mid outputs got %h exp 0", {busy0, done0, ovr0, cwr0, cupd0, cdat0});
        end
`ifdef BIQUAD8_COEFF_READBACK_EN
        rd_adr0 = 1'b1;
`endif
        upd_seen = 0;
        for (int c = 0; c < 8; c++) begin
            if (cupd0 !== 1'b0) upd_seen++;
            tick();
        end
        vectors++;
        if (upd_seen != 0) begin
            miscompares++;
            $display("FAIL reset_mid_update update cycles got %0d exp 0", upd_seen);
        end
`ifdef BIQUAD8_COEFF_READBACK_EN
        vectors++;
        if (rd_dat0 !== 18'h0) begin
            miscompares++;
            $display("FAIL reset_mid_readback got %h exp 0", rd_dat0);
        end
`endif
    endtask

    // Random writes, random commit-cycle write, random busy-time write
    task automatic test_random_sequences();
        logic [17:0] snap [N0];
        logic [4:0]  ef, gf;
        logic [17:0] ed;
        int          r, inj;
        for (int it = 0; it < 10; it++) begin
            for (int w = 0; w < int'($urandom_range(3, 0)); w++)
                write0(1'($urandom), 18'($urandom));
            wr0 = 1'($urandom); adr0 = 1'($urandom); dat0 = 18'($urandom);
            if (wr0) m0[adr0] = dat0;
            commit0 = 1'b1; tick(); commit0 = 1'b0; wr0 = 1'b0;
            snap = m0;
            inj = int'($urandom_range(1, 0));
            r   = int'($urandom_range(N0 + G0 + 2, 1));
            for (int c = 1; c <= 7; c++) begin
                wr0 = (inj != 0 && c == r);
                adr0 = 1'($urandom); dat0 = 18'($urandom);
                ed = (c <= N0) ? snap[N0 - c] : snap[0];
                ef = {c <= N0 + G0 + 2, c == N0 + G0 + 2, inj != 0 && c > r, c <= N0, c == N0 + G0 + 1};
                gf = {busy0, done0, ovr0, cwr0, cupd0};
                vectors++;
                if (gf !== ef || cdat0 !== ed) begin
                    miscompares++;
                    $display("FAIL random it=%0d c=%0d flags got %b exp %b dat got %h exp %h", it, c, gf, ef, cdat0, ed);
                end
                tick();
            end
            wr0 = 1'b0;
        end
    endtask

    // NCOEFF=4, UPDATE_GAP=0, out-of-range writes ignored
    task automatic test_gap0();
        logic [17:0] snap [N1];
        logic [4:0]  ef, gf;
        logic [17:0] ed;
        for (int it = 0; it < 4; it++) begin
            for (int w = 0; w < 6; w++)
                write1(3'($urandom), 18'($urandom));
            commit1 = 1'b1; tick(); commit1 = 1'b0;
            snap = m1;
            for (int c = 1; c <= 8; c++) begin
                ed = (c <= N1) ? snap[N1 - c] : snap[0];
                ef = {c <= N1 + G1 + 2, c == N1 + G1 + 2, 1'b0, c <= N1, c == N1 + G1 + 1};
                gf = {busy1, done1, ovr1, cwr1, cupd1};
                vectors++;
                if (gf !== ef || cdat1 !== ed) begin
                    miscompares++;
                    $display("FAIL gap0 it=%0d c=%0d flags got %b exp %b dat got %h exp %h", it, c, gf, ef, cdat1, ed);
                end
                tick();
            end
        end
    endtask

`ifdef BIQUAD8_COEFF_READBACK_EN
    task automatic test_readback();
        logic [2:0] a;
        write0(1'b1, 18'h2AAAA);
        rd_adr0 = 1'b1;
        tick();
        vectors++;
        if (rd_dat0 !== 18'h2AAAA) begin
            miscompares++;
            $display("FAIL readback_u0 got %h exp 2aaaa", rd_dat0);
        end
        for (int i = 0; i < 8; i++) begin
            a = 3'(i);
            rd_adr1 = a;
            tick();
            vectors++;
            if (rd_dat1 !== ((a < 3'd4) ? m1[a[1:0]] : 18'h0)) begin
                miscompares++;
                $display("FAIL readback_u1 adr=%0d got %h exp %h", a, rd_dat1, (a < 3'd4) ? m1[a[1:0]] : 18'h0);
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_same_cycle_write();
        test_overrun();
        test_random_sequences();
        test_gap0();
`ifdef BIQUAD8_COEFF_READBACK_EN
        test_readback();
`endif
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
